// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Handshake is start/ready in, a one-cycle done pulse out; divide-by-zero is flagged.
module sequential_divider #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         ready_o,
  output logic         done_o,
  output logic         div_by_zero_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [W-1:0]  dividend_r;
  logic [W-1:0]  divisor_r;
  logic [W-1:0]  quotient_r;
  logic [W-1:0]  remainder_r;
  logic [CW-1:0] count_r;
  logic          dbz_r;
  logic          ready_r;
  logic          done_r;
  logic [W:0]    shifted_s;
  logic [W:0]    trial_s;
  logic          fits_s;
  logic          last_iter_s;
  logic          divisor_zero_s;

  // Trial subtraction and iteration bookkeeping for the current OP step.
  always_comb begin
    shifted_s      = {remainder_r, dividend_r[W-1]};
    trial_s        = shifted_s - {1'b0, divisor_r};
    // remainder_r < divisor_r keeps shifted_s below 2*divisor, so bit W is a clean borrow flag
    fits_s         = ~trial_s[W];
    last_iter_s    = (count_r == CW'(W - 1));
    divisor_zero_s = (divisor_i == {W{1'b0}});
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          if (divisor_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = OP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      OP: begin
        if (last_iter_s) begin
          state_s = DONE;
        end else begin
          state_s = OP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered handshake outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand capture and the shift/subtract datapath.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dividend_r  <= {W{1'b0}};
      divisor_r   <= {W{1'b0}};
      quotient_r  <= {W{1'b0}};
      remainder_r <= {W{1'b0}};
      count_r     <= {CW{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            dividend_r <= dividend_i;
            divisor_r  <= divisor_i;
            count_r    <= {CW{1'b0}};
            if (divisor_zero_s) begin
              quotient_r  <= {W{1'b1}};
              remainder_r <= dividend_i;
              dbz_r       <= 1'b1;
            end else begin
              quotient_r  <= {W{1'b0}};
              remainder_r <= {W{1'b0}};
              dbz_r       <= 1'b0;
            end
          end
        end
        OP: begin
          remainder_r <= fits_s ? trial_s[W-1:0] : shifted_s[W-1:0];
          quotient_r  <= {quotient_r[W-2:0], fits_s};
          dividend_r  <= {dividend_r[W-2:0], 1'b0};
          count_r     <= count_r + CW'(1);
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign ready_o       = ready_r;
  assign done_o        = done_r;
  assign div_by_zero_o = dbz_r;
  assign quotient_o    = quotient_r;
  assign remainder_o   = remainder_r;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (W=32): directed cases plus a long
// randomized run, all checked every cycle against an edge-counting arithmetic model.
module tb_sequential_divider;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         reset_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         ready_o;
  logic         done_o;
  logic         div_by_zero_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_on = 1'b0;

  sequential_divider #(.W(W)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .ready_o(ready_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o),
    .quotient_o(quotient_o), .remainder_o(remainder_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void check_word(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic void check_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endfunction

  function automatic void check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endfunction

  // Reference model: counts rising edges since reset; an accepted request fixes
  // the edge on which done_o rises and when the block is ready again.
  int           edge_n = 0;
  int           ready_edge = 0;
  int           done_edge = -1;
  int           n_acc = 0;
  logic [W-1:0] exp_q = '0;
  logic [W-1:0] exp_r = '0;
  logic         exp_z = 1'b0;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      edge_n     <= 0;
      ready_edge <= 0;
      done_edge  <= -1;
      exp_q      <= '0;
      exp_r      <= '0;
      exp_z      <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      if (edge_n >= ready_edge && start_i === 1'b1) begin
        n_acc <= n_acc + 1;
        if (divisor_i == '0) begin
          exp_q      <= '1;
          exp_r      <= dividend_i;
          exp_z      <= 1'b1;
          done_edge  <= edge_n + 1;
          ready_edge <= edge_n + 2;
        end else begin
          exp_q      <= dividend_i / divisor_i;
          exp_r      <= dividend_i % divisor_i;
          exp_z      <= 1'b0;
          done_edge  <= edge_n + 1 + W;
          ready_edge <= edge_n + 2 + W;
        end
      end
    end
  end

  // Compare process: handshake every cycle, results whenever they must be held.
  always @(negedge clk_i) begin
    if (chk_on) begin
      check_bit("ready", ready_o, edge_n >= ready_edge);
      check_bit("done", done_o, edge_n == done_edge);
      check_bit("ready_done_exclusive", ready_o & done_o, 1'b0);
      if (edge_n >= done_edge) begin
        check_word("quotient", quotient_o, exp_q);
        check_word("remainder", remainder_o, exp_r);
        check_bit("div_by_zero", div_by_zero_o, exp_z);
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      3:       return W'(1);
      default: return W'($urandom());
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge where ready_o is seen.
  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check_bit("ready_timeout", ready_o, 1'b1);
  endtask

  // Waits for done_o after an accept on edge acc_e; elat is edges from the
  // accepting edge to the edge raising done_o (0: it rises on the accept edge).
  task automatic wait_done(input string nm, input int acc_e, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic ez, input int elat);
    bit seen = 1'b0;
    int lat = -1;
    for (int i = 0; i < W + 8 && !seen; i++) begin
      @(negedge clk_i);
      if (i % 3 == 0) begin
        dividend_i = $urandom();
        divisor_i  = $urandom();
      end
      if (done_o === 1'b1) begin
        seen = 1'b1;
        lat  = edge_n - acc_e;
        check_word({nm, "_q"}, quotient_o, eq);
        check_word({nm, "_r"}, remainder_o, er);
        check_bit({nm, "_dbz"}, div_by_zero_o, ez);
        check_word({nm, "_model_q"}, exp_q, eq);
        check_word({nm, "_model_r"}, exp_r, er);
      end
    end
    check_bit({nm, "_done_seen"}, seen, 1'b1);
    check_int({nm, "_latency"}, lat, elat);
  endtask

  task automatic run_directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic ez, input int elat);
    int acc_e;
    wait_ready();
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    @(posedge clk_i);
    #1;
    acc_e   = edge_n;
    start_i = 1'b0;
    wait_done(nm, acc_e, eq, er, ez, elat);
  endtask

  initial begin
    int acc_e;
    int nd;
    int d_edge[2];

    repeat (3) @(posedge clk_i);
    #1;
    chk_on = 1'b1;
    check_bit("rst_ready", ready_o, 1'b1);
    check_bit("rst_done", done_o, 1'b0);
    check_bit("rst_dbz", div_by_zero_o, 1'b0);
    check_word("rst_q", quotient_o, 32'd0);
    check_word("rst_r", remainder_o, 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    run_directed("d1000000_4000", 32'd1000000, 32'd4000, 32'd250, 32'd0, 1'b0, 32);
    run_directed("d1000000_3", 32'd1000000, 32'd3, 32'd333333, 32'd1, 1'b0, 32);
    run_directed("d5_7", 32'd5, 32'd7, 32'd0, 32'd5, 1'b0, 32);
    run_directed("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    run_directed("d7_0", 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 0);
    run_directed("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);
    run_directed("d12345_12345", 32'd12345, 32'd12345, 32'd1, 32'd0, 1'b0, 32);
    run_directed("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32);
    run_directed("d0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 32);
    run_directed("d0_0", 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);

    // start_i held high across two requests; operands wiggle while busy.
    wait_ready();
    start_i    = 1'b1;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    @(posedge clk_i);
    #1;
    acc_e = edge_n;
    nd    = 0;
    d_edge[0] = -1;
    d_edge[1] = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk_i);
      #1;
      if (i == 5 || i == 40) begin
        dividend_i = $urandom();
        divisor_i  = $urandom();
      end
      if (i == 20) begin
        dividend_i = 32'd200;
        divisor_i  = 32'd9;
      end
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        if (nd < 2) d_edge[nd] = edge_n;
        check_word("b2b_q", quotient_o, (nd == 0) ? 32'd14 : 32'd22);
        check_word("b2b_r", remainder_o, 32'd2);
        nd++;
        if (nd == 2) start_i = 1'b0;
      end
    end
    check_int("b2b_done_count", nd, 2);
    check_int("b2b_first_latency", d_edge[0] - acc_e, 32);
    check_int("b2b_spacing", d_edge[1] - d_edge[0], 34);

    // Reset in the middle of a division, then a fresh request on the first edge.
    wait_ready();
    start_i    = 1'b1;
    dividend_i = 32'd1000000;
    divisor_i  = 32'd4000;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    reset_ni = 1'b0;
    #1;
    check_bit("abort_ready", ready_o, 1'b1);
    check_bit("abort_done", done_o, 1'b0);
    check_bit("abort_dbz", div_by_zero_o, 1'b0);
    check_word("abort_q", quotient_o, 32'd0);
    check_word("abort_r", remainder_o, 32'd0);
    repeat (2) @(negedge clk_i);
    start_i    = 1'b1;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    reset_ni   = 1'b1;
    @(posedge clk_i);
    #1;
    acc_e = edge_n;
    check_bit("post_reset_accept", ready_o, 1'b0);
    start_i = 1'b0;
    wait_done("d50_5", acc_e, 32'd10, 32'd0, 1'b0, 32);

    // Randomized traffic; the model and compare process judge every cycle.
    for (int c = 0; c < 45000; c++) begin
      @(posedge clk_i);
      #1;
      start_i    = ($urandom_range(0, 9) != 0);
      dividend_i = pick();
      divisor_i  = ($urandom_range(0, 7) == 0) ? dividend_i : pick();
    end
    start_i = 1'b0;
    @(negedge clk_i);
    check_bit("random_op_count", n_acc > 1000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
